// File: rtl/delayed_data_memory.sv
// delayed_data_memory
//   Word-addressed data memory for the MEM stage. Each request completes a
//   fixed LATENCY cycles after it is accepted. Only one request can be
//   outstanding at a time. Busy, the completion pulses and the load
//   destination tag are exported so the hazard unit can stall and forward
//   across the longer load-use window.
// Ports
//   CLK          clock, rising edge
//   CLR          asynchronous active-low reset
//   MemReqM      request valid
//   MemWriteM    1 = store, 0 = load
//   ALUOutM      byte address; bits [1:0] ignored, upper bits wrap modulo DEPTH
//   WriteDataM   store data
//   WriteRegM    load destination register tag
//   Busy         request outstanding; new requests are dropped while high
//   ReadValid    one-cycle pulse, ReadData/WriteRegOut updated
//   WriteDone    one-cycle pulse, store committed to the array
//   ReadData     last load data (held)
//   WriteRegOut  tag of the last completed load (held)
//   Overrun      sticky flag: a request arrived while Busy was high
module delayed_data_memory #(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned DEPTH   = 256,
  parameter string       MEMFILE = ""
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  WriteRegM,
  output logic        Busy,
  output logic        ReadValid,
  output logic        WriteDone,
  output logic [31:0] ReadData,
  output logic [4:0]  WriteRegOut,
  output logic        Overrun
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned TAG_W  = 5;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = 4;
  localparam bit          MEMFILE_EN = (MEMFILE != "");

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    count;
  logic                reqWrite;
  logic [IDX_W-1:0]    reqIdx;
  logic [WORD_W-1:0]   reqData;
  logic [TAG_W-1:0]    reqTag;
  logic [WORD_W-1:0]   mem [0:DEPTH-1];

  logic                complete;
  logic                unusedAddr;

  // Offset bits and bits above the index play no part in addressing.
  assign unusedAddr = ^{ALUOutM[31:IDX_W+2], ALUOutM[1:0], MEMFILE_EN};

  // Last WAIT cycle; the completion edge of the outstanding request.
  assign complete = (state == WAIT) && (count == '0);

  // Array write port; not reset so contents survive CLR. A reset during WAIT
  // forces IDLE, which suppresses the pending commit.
  always_ff @(posedge CLK) begin
    if (complete && reqWrite) begin
      mem[reqIdx] <= reqData;
    end
  end

  // Request FSM with registered status and response outputs.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state       <= IDLE;
      count       <= '0;
      reqWrite    <= 1'b0;
      reqIdx      <= '0;
      reqData     <= '0;
      reqTag      <= '0;
      Busy        <= 1'b0;
      ReadValid   <= 1'b0;
      WriteDone   <= 1'b0;
      ReadData    <= '0;
      WriteRegOut <= '0;
      Overrun     <= 1'b0;
    end else begin
      ReadValid <= 1'b0;
      WriteDone <= 1'b0;
      // Busy is high on the completion edge too, so a request there is dropped.
      if (MemReqM && Busy) begin
        Overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (MemReqM) begin
            reqWrite <= MemWriteM;
            reqIdx   <= ALUOutM[IDX_W+1:2];
            reqData  <= WriteDataM;
            reqTag   <= WriteRegM;
            count    <= CNT_W'(LATENCY - 1);
            state    <= WAIT;
            Busy     <= 1'b1;
          end
        end
        WAIT: begin
          if (count == '0) begin
            state <= IDLE;
            Busy  <= 1'b0;
            if (reqWrite) begin
              WriteDone <= 1'b1;
            end else begin
              ReadData    <= mem[reqIdx];
              WriteRegOut <= reqTag;
              ReadValid   <= 1'b1;
            end
          end else begin
            count <= count - CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delayed_data_memory.sv
// Bench for delayed_data_memory: DUT 0 uses LATENCY=3, DUT 1 uses LATENCY=1.
// Stimulus pushes expected completions (kind, data, tag, cycle) into a queue
// per DUT; a negedge monitor pops and compares whenever a pulse appears.
module tb_delayed_data_memory;

  typedef struct {
    logic        isRead;
    logic [31:0] data;
    logic [4:0]  tag;
    int          due;
  } exp_t;

  logic        CLK;
  logic        clrN  [2];
  logic        req   [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [4:0]  tag   [2];
  logic        busy  [2];
  logic        rv    [2];
  logic        wd    [2];
  logic [31:0] rdata [2];
  logic [4:0]  rtag  [2];
  logic        ovr   [2];

  exp_t qA[$];
  exp_t qB[$];
  int   lat [2] = '{3, 1};
  int   cyc = 0;
  int   nCmp = 0;
  int   nErr = 0;

  delayed_data_memory #(.LATENCY(3), .DEPTH(256), .MEMFILE("")) dut0 (
    .CLK(CLK), .CLR(clrN[0]), .MemReqM(req[0]), .MemWriteM(wr[0]),
    .ALUOutM(addr[0]), .WriteDataM(wdata[0]), .WriteRegM(tag[0]),
    .Busy(busy[0]), .ReadValid(rv[0]), .WriteDone(wd[0]),
    .ReadData(rdata[0]), .WriteRegOut(rtag[0]), .Overrun(ovr[0])
  );

  delayed_data_memory #(.LATENCY(1), .DEPTH(256), .MEMFILE("")) dut1 (
    .CLK(CLK), .CLR(clrN[1]), .MemReqM(req[1]), .MemWriteM(wr[1]),
    .ALUOutM(addr[1]), .WriteDataM(wdata[1]), .WriteRegM(tag[1]),
    .Busy(busy[1]), .ReadValid(rv[1]), .WriteDone(wd[1]),
    .ReadData(rdata[1]), .WriteRegOut(rtag[1]), .Overrun(ovr[1])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Drive one request at the current (negedge) time; it is accepted next edge.
  task automatic issue(input int d, input logic w, input logic [31:0] a,
                       input logic [31:0] dat, input logic [4:0] t,
                       input logic [31:0] expData, input bit doPush);
    exp_t e;
    e.isRead = ~w;
    e.data   = expData;
    e.tag    = t;
    e.due    = cyc + 1 + lat[d];
    req[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = dat; tag[d] = t;
    if (doPush) begin
      if (d == 0) qA.push_back(e);
      else        qB.push_back(e);
    end
    @(posedge CLK);
    #1;
    req[d] = 1'b0;
  endtask

  // Count negedges with Busy high; returns at the first negedge with Busy low.
  task automatic busyRun(input int d, output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (busy[d]) n++;
      else break;
    end
  endtask

  // Scoreboard monitor.
  always @(negedge CLK) begin
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      bit   have;
      if (rv[d] || wd[d]) begin
        have = 1'b0;
        if (d == 0 && qA.size() > 0) begin e = qA.pop_front(); have = 1'b1; end
        if (d == 1 && qB.size() > 0) begin e = qB.pop_front(); have = 1'b1; end
        if (!have) begin
          check($sformatf("dut%0d unexpected completion pulse", d), 32'd1, 32'd0);
        end else begin
          check($sformatf("dut%0d completion kind (ReadValid)", d), 32'(rv[d]), 32'(e.isRead));
          check($sformatf("dut%0d ReadValid&WriteDone overlap", d), 32'(rv[d] & wd[d]), 32'd0);
          check($sformatf("dut%0d completion cycle", d), 32'(cyc), 32'(e.due));
          if (e.isRead) begin
            check($sformatf("dut%0d ReadData", d), rdata[d], e.data);
            check($sformatf("dut%0d WriteRegOut", d), 32'(rtag[d]), 32'(e.tag));
          end
        end
      end
    end
  end

  initial begin
    int n;
    int base;
    logic        t5w [4];
    logic [31:0] t5a [4];
    logic [31:0] t5d [4];
    logic [4:0]  t5t [4];
    logic [31:0] t5e [4];
    exp_t e;

    t5w = '{1'b1, 1'b0, 1'b1, 1'b0};
    t5a = '{32'h40, 32'h40, 32'h44, 32'h44};
    t5d = '{32'h11111111, 32'h0, 32'h22222222, 32'h0};
    t5t = '{5'd0, 5'd1, 5'd0, 5'd2};
    t5e = '{32'h0, 32'h11111111, 32'h0, 32'h22222222};

    for (int d = 0; d < 2; d++) begin
      clrN[d] = 1'b1; req[d] = 1'b0; wr[d] = 1'b0;
      addr[d] = '0; wdata[d] = '0; tag[d] = '0;
    end
    #1;
    clrN[0] = 1'b0; clrN[1] = 1'b0;
    #1;
    check("reset Busy", 32'(busy[0]), 32'd0);
    check("reset ReadValid", 32'(rv[0]), 32'd0);
    check("reset WriteDone", 32'(wd[0]), 32'd0);
    check("reset ReadData", rdata[0], 32'd0);
    check("reset WriteRegOut", 32'(rtag[0]), 32'd0);
    check("reset Overrun", 32'(ovr[0]), 32'd0);
    check("dut1 reset Busy", 32'(busy[1]), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    clrN[0] = 1'b1; clrN[1] = 1'b1;

    // Store then load of the same word, load issued as Busy falls.
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0, 32'h0, 1'b1);
    busyRun(0, n);
    check("t1 store Busy cycles", 32'(n), 32'd3);
    issue(0, 1'b0, 32'h10, 32'h0, 5'd5, 32'hDEADBEEF, 1'b1);
    busyRun(0, n);
    check("t1 load Busy cycles", 32'(n), 32'd3);

    // Low address bits ignored, high bits wrap.
    issue(0, 1'b0, 32'h13, 32'h0, 5'd9, 32'hDEADBEEF, 1'b1);
    busyRun(0, n);
    issue(0, 1'b0, 32'h410, 32'h0, 5'd10, 32'hDEADBEEF, 1'b1);
    busyRun(0, n);
    repeat (3) @(negedge CLK);
    check("t2 ReadData hold", rdata[0], 32'hDEADBEEF);
    check("t2 WriteRegOut hold", 32'(rtag[0]), 32'd10);
    check("t2 Overrun still clear", 32'(ovr[0]), 32'd0);

    // Request while Busy is dropped and sets sticky Overrun.
    issue(0, 1'b1, 32'h24, 32'h55AA55AA, 5'd0, 32'h0, 1'b1);
    @(negedge CLK);
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h10; tag[0] = 5'd12;
    @(posedge CLK);
    #1;
    req[0] = 1'b0;
    busyRun(0, n);
    check("t3 remaining Busy cycles", 32'(n), 32'd2);
    check("t3 Overrun set", 32'(ovr[0]), 32'd1);
    issue(0, 1'b0, 32'h24, 32'h0, 5'd3, 32'h55AA55AA, 1'b1);
    busyRun(0, n);
    check("t3 Overrun sticky", 32'(ovr[0]), 32'd1);

    // Reset during WAIT of a store: outputs clear at once, store is lost.
    issue(0, 1'b1, 32'h20, 32'hCAFE0000, 5'd0, 32'h0, 1'b1);
    busyRun(0, n);
    issue(0, 1'b1, 32'h20, 32'h00001234, 5'd0, 32'h0, 1'b0);
    @(negedge CLK);
    check("t4 Busy before reset", 32'(busy[0]), 32'd1);
    #2;
    clrN[0] = 1'b0;
    #1;
    check("t4 async Busy", 32'(busy[0]), 32'd0);
    check("t4 async ReadValid", 32'(rv[0]), 32'd0);
    check("t4 async WriteDone", 32'(wd[0]), 32'd0);
    check("t4 async ReadData", rdata[0], 32'd0);
    check("t4 async WriteRegOut", 32'(rtag[0]), 32'd0);
    check("t4 async Overrun", 32'(ovr[0]), 32'd0);
    @(negedge CLK);
    clrN[0] = 1'b1;
    issue(0, 1'b0, 32'h20, 32'h0, 5'd7, 32'hCAFE0000, 1'b1);
    busyRun(0, n);
    check("t4 load Busy cycles", 32'(n), 32'd3);

    // MemReqM held high: one accept every LATENCY+1 cycles.
    base = cyc;
    for (int i = 0; i < 4; i++) begin
      req[0] = 1'b1; wr[0] = t5w[i]; addr[0] = t5a[i];
      wdata[0] = t5d[i]; tag[0] = t5t[i];
      e.isRead = ~t5w[i];
      e.data   = t5e[i];
      e.tag    = t5t[i];
      e.due    = base + 1 + 4 * i + 3;
      qA.push_back(e);
      if (i == 0) @(posedge CLK);
      else        repeat (4) @(posedge CLK);
      #1;
    end
    req[0] = 1'b0;
    busyRun(0, n);
    check("t5 final Busy cycles", 32'(n), 32'd3);

    // LATENCY=1 instance, store then load.
    issue(1, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0, 32'h0, 1'b1);
    busyRun(1, n);
    check("t6 store Busy cycles", 32'(n), 32'd1);
    issue(1, 1'b0, 32'h10, 32'h0, 5'd5, 32'hDEADBEEF, 1'b1);
    busyRun(1, n);
    check("t6 load Busy cycles", 32'(n), 32'd1);

    repeat (4) @(negedge CLK);
    check("dut0 outstanding expectations", 32'(qA.size()), 32'd0);
    check("dut1 outstanding expectations", 32'(qB.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
